// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and immediate format codes for the immediate
// generator, issue and branch units.
package imm_gen_pipe_pkg;

    localparam logic [6:0] ItypeL = 7'b0000011;  // loads
    localparam logic [6:0] ItypeA = 7'b0010011;  // OP-IMM
    localparam logic [6:0] ItypeJ = 7'b1100111;  // JALR
    localparam logic [6:0] ItypeW = 7'b0011011;  // OP-IMM-32, RV64 only
    localparam logic [6:0] Stype  = 7'b0100011;
    localparam logic [6:0] Btype  = 7'b1100011;
    localparam logic [6:0] UtypeL = 7'b0110111;  // LUI
    localparam logic [6:0] UtypeU = 7'b0010111;  // AUIPC
    localparam logic [6:0] Jtype  = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> {sign-extended immediate, format class}.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      kind
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        kind  = IMM_NONE;
        unique case (inst[6:0])
            ItypeL, ItypeA, ItypeJ: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                kind  = IMM_I;
            end
            ItypeW: begin
                if (XLEN == 64) begin
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                    kind  = IMM_I;
                end
            end
            Stype: begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                kind  = IMM_S;
            end
            Btype: begin
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                kind  = IMM_B;
            end
            UtypeL, UtypeU: begin
                imm32 = {inst[31:12], 12'b0};
                kind  = IMM_U;
            end
            Jtype: begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                kind  = IMM_J;
            end
            default: ;
        endcase
    end

    // Bit 31 of every 32-bit immediate already carries the sign, including U.
    always_comb begin
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with 2-entry skid FIFO (1-cycle latency).
// Define IMM_GEN_TRACE_EN to print B/J results as they leave the block.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       imm_type,
    output logic [XLEN-1:0]  target_o,
    output logic [TAG_W-1:0] tag_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       kind;
        logic [XLEN-1:0]  target;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_kind;
    entry_t          wdata;
    entry_t          mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;
    logic            push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst (inst),
        .imm  (dec_imm),
        .kind (dec_kind)
    );

    always_comb begin
        wdata.imm    = dec_imm;
        wdata.kind   = dec_kind;
        wdata.target = pc + dec_imm;
        wdata.tag    = tag_i;
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count > 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Entries are cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign imm_o    = mem[rd_ptr].imm;
    assign imm_type = mem[rd_ptr].kind;
    assign target_o = mem[rd_ptr].target;
    assign tag_o    = mem[rd_ptr].tag;

`ifdef IMM_GEN_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && pop && (imm_type == IMM_B || imm_type == IMM_J))
            $display("imm_branch : %h %h", imm_o, target_o);
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  ty;
        logic [63:0] tgt;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic [31:0] inst = '0;
    logic [63:0] pc = '0;
    logic [7:0]  tag = '0;
    logic        v32 = 0, v64 = 0;
    logic        ordy32 = 0;
    logic        rdy32, rdy64, ov32, ov64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  ty32, ty64;
    logic [7:0]  tago32, tago64;

    int total = 0;
    int bad = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v32), .in_ready(rdy32),
        .inst(inst), .pc(pc[31:0]), .tag_i(tag), .out_valid(ov32), .out_ready(ordy32),
        .imm_o(imm32), .imm_type(ty32), .target_o(tgt32), .tag_o(tago32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v64), .in_ready(rdy64),
        .inst(inst), .pc(pc), .tag_i(tag), .out_valid(ov64), .out_ready(1'b1),
        .imm_o(imm64), .imm_type(ty64), .target_o(tgt64), .tag_o(tago64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov32 && ordy32) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected32: got imm %h with empty queue", imm32);
            end else begin
                e = q32.pop_front();
                chk("imm32", {32'b0, imm32}, {32'b0, e.imm[31:0]});
                chk("type32", {61'b0, ty32}, {61'b0, e.ty});
                chk("target32", {32'b0, tgt32}, {32'b0, e.tgt[31:0]});
                chk("tag32", {56'b0, tago32}, {56'b0, e.tag});
            end
        end
        if (!rst && ov64) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected64: got imm %h with empty queue", imm64);
            end else begin
                e = q64.pop_front();
                chk("imm64", imm64, e.imm);
                chk("type64", {61'b0, ty64}, {61'b0, e.ty});
                chk("target64", tgt64, e.tgt);
                chk("tag64", {56'b0, tago64}, {56'b0, e.tag});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input bit w64, input logic [31:0] i, input logic [63:0] p,
                        input logic [7:0] t, input logic [63:0] ei, input logic [2:0] et,
                        input logic [63:0] eg);
        int n = 0;
        exp_t e;
        inst = i; pc = p; tag = t;
        if (w64) v64 = 1; else v32 = 1;
        while (!(w64 ? rdy64 : rdy32) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: inst %h never accepted, required acceptance", i);
        end else begin
            e.imm = ei; e.ty = et; e.tgt = eg; e.tag = t;
            if (w64) q64.push_back(e); else q32.push_back(e);
        end
        tick();
        v32 = 0; v64 = 0;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_out_valid", {63'b0, ov32}, 64'd0);
        chk("rst_in_ready", {63'b0, rdy32}, 64'd1);
        chk("rst_imm", {32'b0, imm32}, 64'd0);
        chk("rst_type", {61'b0, ty32}, 64'd0);
        chk("rst_target", {32'b0, tgt32}, 64'd0);
        chk("rst_tag", {56'b0, tago32}, 64'd0);

        ordy32 = 1;
        send(0, 32'hFFF00093, 64'h0, 8'h11, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF);
        chk("latency_out_valid", {63'b0, ov32}, 64'd1);
        send(0, 32'hFE000EE3, 64'h100, 8'h22, 64'hFFFFFFFC, 3'd3, 64'hFC);
        send(0, 32'h0080006F, 64'hFFFFFFFC, 8'h33, 64'h8, 3'd5, 64'h4);
        send(0, 32'hFE112E23, 64'h40, 8'h44, 64'hFFFFFFFC, 3'd2, 64'h3C);
        send(0, 32'hFFF0009B, 64'h10, 8'h55, 64'h0, 3'd0, 64'h10);
        tick();

        // Backpressure: two accepted, third held until the consumer drains.
        ordy32 = 0;
        send(0, 32'h12345037, 64'h1000, 8'h61, 64'h12345000, 3'd4, 64'h12346000);
        send(0, 32'h0080006F, 64'h2000, 8'h62, 64'h8, 3'd5, 64'h2008);
        inst = 32'hFFF00093; pc = 64'h3000; tag = 8'h63; v32 = 1;
        chk("full_in_ready", {63'b0, rdy32}, 64'd0);
        tick();
        chk("hold_in_ready", {63'b0, rdy32}, 64'd0);
        chk("hold_head_imm", {32'b0, imm32}, 64'h12345000);
        ordy32 = 1;
        send(0, 32'hFFF00093, 64'h3000, 8'h63, 64'hFFFFFFFF, 3'd1, 64'h2FFF);
        tick(); tick();

        // Flush while full with a pending input: everything is dropped.
        ordy32 = 0;
        send(0, 32'hFFF00093, 64'h0, 8'h71, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF);
        send(0, 32'hFE000EE3, 64'h100, 8'h72, 64'hFFFFFFFC, 3'd3, 64'hFC);
        inst = 32'h0080006F; pc = 64'h0; tag = 8'h73; v32 = 1; flush = 1;
        tick();
        flush = 0; v32 = 0;
        q32.delete();
        chk("flush_out_valid", {63'b0, ov32}, 64'd0);
        chk("flush_in_ready", {63'b0, rdy32}, 64'd1);
        ordy32 = 1;
        tick(); tick();

        // Reset mid-stream.
        ordy32 = 0;
        send(0, 32'h12345037, 64'h1000, 8'h81, 64'h12345000, 3'd4, 64'h12346000);
        rst = 1;
        tick();
        rst = 0;
        q32.delete();
        chk("mid_rst_out_valid", {63'b0, ov32}, 64'd0);
        chk("mid_rst_in_ready", {63'b0, rdy32}, 64'd1);
        chk("mid_rst_imm", {32'b0, imm32}, 64'd0);
        chk("mid_rst_target", {32'b0, tgt32}, 64'd0);
        chk("mid_rst_tag", {56'b0, tago32}, 64'd0);
        ordy32 = 1;

        // XLEN=64 instance.
        send(1, 32'h800000B7, 64'h0, 8'h91, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000000);
        send(1, 32'hFFF0009B, 64'h10, 8'h92, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hF);
        send(1, 32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 8'h93, 64'h8, 3'd5, 64'h4);
        send(1, 32'h00000000, 64'h1234, 8'h94, 64'h0, 3'd0, 64'h1234);
        tick(); tick(); tick();

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Sits between the decode and issue stages. Accepts one instruction per cycle over a valid/ready handshake.
- Outputs the XLEN-wide sign-extended immediate, its format class and the PC-relative target (pc + imm). Latency is 1 cycle.
- A 2-entry skid buffer keeps full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width: 32 or 64. Any other value is a compile-time error.
- TAG_W, 8, width of the opaque sideband tag, such as ROB id, carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  instruction address.
- tag_i  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- imm_o  out  XLEN  sign-extended immediate.
- imm_type  out  3  format class: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- target_o  out  XLEN  pc + imm_o, modulo 2^XLEN.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Clocking and reset: one clock. rst is synchronous and active-high.
- Reset values: out_valid=0, imm_o=0, imm_type=0, target_o=0, tag_o=0, skid buffer empty. in_ready=1 in the first cycle after reset.
- Decode by opcode inst[6:0]:
  - I: 0000011, 0010011, 1100111.
  - I: 0011011 (OP-IMM-32), only when XLEN=64. When XLEN=32 this opcode decodes as NONE.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode: NONE, with imm_o=0 and target_o=pc.
- Immediate fields:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Sign extension: every immediate is sign-extended from inst[31] to XLEN. This includes U when XLEN=64.
- Storage: 2-entry FIFO of {imm, type, target, tag}. The head entry drives the out_* ports.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output accept = out_valid & out_ready.
  - in_ready = (count < 2), a registered-state function only with no combinational path from out_ready.
  - out_valid = (count > 0).
- Latency: an instruction accepted in cycle N is visible on out_* in cycle N+1 if the buffer was empty.
- Occupancy:
  - Simultaneous accept and output accept keeps the count unchanged.
  - Accept with count=1 and out_ready=0 fills the buffer, so in_ready=0 next cycle.
  - When full, in_valid is ignored. Upstream must hold inst until accepted.
- Ordering: strict FIFO order. Output fields stay stable while out_valid=1 and out_ready=0.
- flush: empties the buffer in the same edge and has priority over a simultaneous input accept, so the input is dropped. out_valid=0 next cycle.
- rst: has priority over flush. Reset mid-operation discards all entries.
- Wrap: read and write pointers are 1 bit each and wrap modulo 2. Count is 2 bits and saturates by construction.

Optional Feature:
- Macro: IMM_GEN_TRACE_EN.
- Defined: on each output accept of a B- or J-type entry, a simulation display prints "imm_branch :" followed by imm_o and target_o. This logic is excluded from synthesis.
- Undefined: no display statements and no trace logic. Port list and timing are identical.

Decomposition:
- Shared package/header: opcode constants (`ItypeL, `ItypeA, `ItypeJ, `Stype, `Btype, `UtypeL, `UtypeU, `Jtype, plus new `ItypeW), and IMM_* type codes 0-5 for reuse by issue/branch units.
- Sub-module imm_decode: purely combinational inst -> {imm, type}, parametrised by XLEN.
- imm_gen_pipe instantiates imm_decode, the adder and the 2-entry skid FIFO.

Test Plan:
- XLEN=32, inst=0xFFF00093 (addi -1), pc=0x0, tag=0x11 -> next cycle: out_valid=1, imm_o=0xFFFFFFFF, imm_type=1, tag_o=0x11.
- inst=0xFE000EE3 (beq -4), pc=0x100 -> imm_o=0xFFFFFFFC, type=3, target_o=0x000000FC. Trace line printed only with IMM_GEN_TRACE_EN.
- inst=0x0080006F (jal +8), pc=0xFFFFFFFC -> imm_o=8, type=5, target_o=0x00000004 (wrap-around).
- Backpressure: out_ready=0, present lui 0x12345037 then 0x0080006F then 0xFFF00093 on consecutive cycles:
  - First two accepted, then in_ready=0 and the third is held.
  - out_ready=1 then drains 0x12345000, 0x8, 0xFFFFFFFF in order, one per cycle.
- flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears. rst asserted mid-stream gives the same result and all outputs read 0.
- XLEN=64:
  - inst=0x800000B7 (lui 0x80000) -> imm_o=0xFFFFFFFF80000000.
  - inst=0xFFF0009B (addiw -1) -> type=1, imm_o=all ones.
  - Same 0xFFF0009B under XLEN=32 -> type=0, imm_o=0.
